// File: rtl/ebr_sdp_ram.sv
// Simple-dual-port block RAM with one bit-masked write port and one read port on one clock.
// Options: output register, read-during-write old/new data, and a clear sweep after reset.
module ebr_sdp_ram #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       RD_MODE    = 0,
  parameter int unsigned       OUT_REG    = 0,
  parameter int unsigned       CLR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_mask_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam bit                CLR_EN    = (CLR_ON_RST != 0);
  localparam bit                RD_NEW    = (RD_MODE != 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                busy_q, busy_d;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                ready_c;
  logic                wr_acc_c;
  logic                rd_acc_c;
  logic                collide_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_addr_c;
  logic [DATA_W-1:0]   mem_bits_c;
  logic [DATA_W-1:0]   mem_data_c;
  logic [DATA_W-1:0]   rd_word_c;
  logic [DATA_W-1:0]   rd_merge_c;
  logic [DATA_W-1:0]   rd_sel_c;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Requests are only honoured once the clear sweep has finished.
  assign ready_c  = (state_q == ST_READY);
  assign wr_acc_c = wr_en & ready_c;
  assign rd_acc_c = rd_en & ready_c;

  // Next-state logic for the clear sweep.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLR_EN ? ST_CLEAR : ST_READY;
      busy_q    <= CLR_EN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Single physical write port shared by the sweep and user writes.
  always_comb begin
    mem_we_c   = 1'b0;
    mem_addr_c = wr_addr;
    mem_bits_c = ~wr_mask_n;
    mem_data_c = wr_data;
    if (state_q == ST_CLEAR) begin
      mem_we_c   = 1'b1;
      mem_addr_c = clr_cnt_q;
      mem_bits_c = '1;
      mem_data_c = CLR_VAL;
    end else begin
      mem_we_c   = wr_acc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (mem_bits_c[i]) begin
          mem_q[mem_addr_c][i] <= mem_data_c[i];
        end
      end
    end
  end

  // Read word, optionally bypassing the same-cycle write with merged data.
  assign rd_word_c  = mem_q[rd_addr];
  assign rd_merge_c = (rd_word_c & wr_mask_n) | (wr_data & ~wr_mask_n);
  assign collide_c  = wr_acc_c & (wr_addr == rd_addr);
  assign rd_sel_c   = (RD_NEW && collide_c) ? rd_merge_c : rd_word_c;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s1_valid_q;
      logic [DATA_W-1:0] s1_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_acc_c;
          if (rd_acc_c) begin
            s1_data_q <= rd_sel_c;
          end
          rd_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            rd_data_q <= s1_data_q;
          end
        end
      end
    end else begin : g_no_out_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          rd_valid_q <= rd_acc_c;
          if (rd_acc_c) begin
            rd_data_q <= rd_sel_c;
          end
        end
      end
    end
  endgenerate

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;

endmodule
